// File: rtl/vector_result_drain.sv
// Shadow-buffers one N-element ALU result vector and streams it out one element per valid/ready beat.
// Optional VEC_DRAIN_SUM_EN appends a wrap-around sum beat after the last element.
module vector_result_drain #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BITS-1:0]  vec_in [N-1:0],
  input  logic             vec_valid,
  output logic             vec_ready,
  output logic [BITS-1:0]  m_data,
  output logic [IDX_W-1:0] m_index,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             dropped,
  input  logic             clr_dropped
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [BITS-1:0]  shadow_q [N-1:0];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dropped_q, dropped_d;
  logic             capture, xfer, at_end;

`ifdef VEC_DRAIN_SUM_EN
  logic [BITS-1:0]  acc_q, acc_d;
  logic             sum_q, sum_d;
`endif

  assign capture = vec_valid && (state_q == IDLE);
  assign xfer    = (state_q == SEND) && m_ready;
  assign at_end  = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dropped_d = dropped_q;
`ifdef VEC_DRAIN_SUM_EN
    acc_d     = acc_q;
    sum_d     = sum_q;
`endif
    // Set has priority over clear so an overlap in the same cycle is never lost.
    if (vec_valid && (state_q == SEND)) dropped_d = 1'b1;
    else if (clr_dropped)               dropped_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = '0;
`ifdef VEC_DRAIN_SUM_EN
          acc_d   = '0;
          sum_d   = 1'b0;
`endif
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef VEC_DRAIN_SUM_EN
          if (sum_q) begin
            state_d = IDLE;
            sum_d   = 1'b0;
            idx_d   = '0;
          end else begin
            acc_d = acc_q + shadow_q[idx_q];
            if (at_end) begin
              sum_d = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
`else
          if (at_end) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dropped_q <= 1'b0;
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
`ifdef VEC_DRAIN_SUM_EN
      acc_q     <= '0;
      sum_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
      if (capture) shadow_q <= vec_in;
`ifdef VEC_DRAIN_SUM_EN
      acc_q     <= acc_d;
      sum_q     <= sum_d;
`endif
    end
  end

  assign vec_ready = (state_q == IDLE);
  assign busy      = (state_q == SEND);
  assign m_valid   = (state_q == SEND);
  assign m_index   = idx_q;
  assign dropped   = dropped_q;

`ifdef VEC_DRAIN_SUM_EN
  assign m_data = sum_q ? acc_q : shadow_q[idx_q];
  assign m_last = (state_q == SEND) && sum_q;
`else
  assign m_data = shadow_q[idx_q];
  assign m_last = (state_q == SEND) && at_end;
`endif

endmodule
